// File: rtl/mag_det_pkg.sv
// Shared defaults and state encoding for the squared-magnitude peak detector.
package mag_det_pkg;

    localparam int DEF_DATA_W  = 31;
    localparam int DEF_IDX_W   = 10;
    localparam int DEF_MAX_LEN = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } det_state_t;

endpackage

// File: rtl/mag_peak_detect.sv
// Per-frame peak search over squared-magnitude samples: tracks the maximum,
// its first index and the number of threshold hits, then holds one result
// until the consumer takes it.
module mag_peak_detect
    import mag_det_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [DATA_W-1:0] thresh,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_peak,
    output logic [IDX_W-1:0]  m_index,
    output logic [IDX_W:0]    m_nhits,
    output logic              m_detect,
    output logic              m_ovf
);

    // Count is one bit wider than the index so MAX_LEN itself is representable.
    localparam logic [IDX_W:0] LEN_C = (IDX_W+1)'(MAX_LEN);

    det_state_t          r_state;
    logic [DATA_W-1:0]   r_thr;
    logic [DATA_W-1:0]   r_peak;
    logic [IDX_W-1:0]    r_index;
    logic [IDX_W:0]      r_count;
    logic [IDX_W:0]      r_nhits;
    logic                r_detect;
    logic                r_ovf;
    logic                r_mvalid;

    logic                w_xfer;
    logic [DATA_W-1:0]   w_thr;
    logic                w_hit;
    logic                w_gt;
    logic [DATA_W-1:0]   w_peak;
    logic [IDX_W-1:0]    w_index;
    logic [IDX_W:0]      w_count;
    logic [IDX_W:0]      w_nhits;
    logic                w_full;
    logic                w_end;

    assign s_ready = (r_state != ST_REPORT);
    assign w_xfer  = s_valid && s_ready;

    // Next accumulator values if the current sample transfers; the first
    // sample of a frame seeds everything and latches the live threshold.
    always_comb begin
        w_thr   = (r_state == ST_IDLE) ? thresh : r_thr;
        w_hit   = (s_data >= w_thr);
        w_gt    = 1'b0;
        w_peak  = r_peak;
        w_index = r_index;
        w_count = r_count;
        w_nhits = r_nhits;
        if (r_state == ST_IDLE) begin
            w_peak  = s_data;
            w_index = '0;
            w_count = (IDX_W+1)'(1);
            w_nhits = (IDX_W+1)'(w_hit);
        end else begin
            w_gt    = (s_data > r_peak);
            w_peak  = w_gt ? s_data : r_peak;
            w_index = w_gt ? r_count[IDX_W-1:0] : r_index;
            w_count = r_count + (IDX_W+1)'(1);
            w_nhits = r_nhits + (IDX_W+1)'(w_hit);
        end
        w_full = (w_count == LEN_C);
        w_end  = s_last || w_full;
    end

    // Frame FSM with accumulators and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_thr    <= '0;
            r_peak   <= '0;
            r_index  <= '0;
            r_count  <= '0;
            r_nhits  <= '0;
            r_detect <= 1'b0;
            r_ovf    <= 1'b0;
            r_mvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_SCAN: begin
                    if (w_xfer) begin
                        r_thr   <= w_thr;
                        r_peak  <= w_peak;
                        r_index <= w_index;
                        r_count <= w_count;
                        r_nhits <= w_nhits;
                        if (w_end) begin
                            r_state  <= ST_REPORT;
                            r_mvalid <= 1'b1;
                            r_detect <= (w_peak >= w_thr);
                            // Truncation only when the frame ran out of room
                            // without the producer marking its end.
                            r_ovf    <= !s_last;
                        end else begin
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_REPORT: begin
                    if (m_ready) begin
                        r_state  <= ST_IDLE;
                        r_mvalid <= 1'b0;
                        r_count  <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_valid  = r_mvalid;
    assign m_peak   = r_peak;
    assign m_index  = r_index;
    assign m_nhits  = r_nhits;
    assign m_detect = r_detect;
    assign m_ovf    = r_ovf;

endmodule

// File: doc/mag_peak_detect.md
MAG_PEAK_DETECT -- requirements
Module: mag_peak_detect

Interface
REQ-001 SHALL have parameter DATA_W, default 31, width of squared-magnitude samples (|x|^2+|y|^2).
REQ-002 SHALL have parameter IDX_W, default 10, width of the sample index and counters.
REQ-003 SHALL have parameter MAX_LEN, default 1024, maximum samples per frame (at most 2^IDX_W).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_valid  in  1  input sample valid.
REQ-007 SHALL have port s_ready  out  1  block accepts a sample this cycle.
REQ-008 SHALL have port s_data  in  DATA_W  squared-magnitude sample, unsigned.
REQ-009 SHALL have port s_last  in  1  last sample of the frame (range line).
REQ-010 SHALL have port thresh  in  DATA_W  detection threshold, unsigned.
REQ-011 SHALL have port m_valid  out  1  frame result valid.
REQ-012 SHALL have port m_ready  in  1  consumer accepts the result.
REQ-013 SHALL have port m_peak  out  DATA_W  maximum sample of the frame.
REQ-014 SHALL have port m_index  out  IDX_W  index of the first occurrence of the maximum.
REQ-015 SHALL have port m_nhits  out  IDX_W+1  number of samples >= threshold.
REQ-016 SHALL have port m_detect  out  1  m_peak >= threshold.
REQ-017 SHALL have port m_ovf  out  1  frame was truncated at MAX_LEN.

Function
REQ-018 SHALL use states IDLE, SCAN, REPORT; a sample transfers when s_valid && s_ready.
REQ-019 SHALL drive s_ready=1 in IDLE and SCAN, 0 in REPORT.
REQ-020 SHALL, on a transfer in IDLE, capture thresh into a frame register, set peak=s_data, index=0, count=1, nhits=(s_data>=thresh), and go to SCAN.
REQ-021 SHALL, on a transfer in SCAN, set peak/index to s_data/count only if s_data > peak (strict; ties keep earliest index), increment count, and increment nhits if s_data >= frame threshold.
REQ-022 SHALL leave thresh changes mid-frame without effect; only the value captured at the first sample is used.
REQ-023 SHALL move to REPORT on the transfer carrying s_last, in either IDLE (single-sample frame) or SCAN.
REQ-024 SHALL move to REPORT with m_ovf=1 when the MAX_LEN-th sample transfers without s_last; subsequent samples start a new frame.
REQ-025 SHALL assert m_valid in the cycle after the terminating transfer (latency 1) and hold all m_* outputs stable until m_valid && m_ready.
REQ-026 SHALL return to IDLE on the m_ready handshake; s_ready rises the following cycle (no input accepted in the handshake cycle).
REQ-027 SHALL compute comparisons unsigned at full DATA_W; nhits SHALL not wrap (IDX_W+1 bits covers MAX_LEN).
REQ-028 SHALL ignore s_last and s_data when s_valid=0; m_ready ignored when m_valid=0.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE and clear m_valid, m_peak, m_index, m_nhits, m_detect, m_ovf and all internal counters to 0, s_ready=1 the following cycle.
REQ-030 SHALL, on reset mid-frame or in REPORT, discard the partial frame/result with no m_valid emitted.

Structure
REQ-031 SHALL place DATA_W/IDX_W/MAX_LEN defaults and the state enumeration in shared package mag_det_pkg.
REQ-032 SHALL be a single module with no sub-module; the compare/accumulate datapath is inline.

Verification
REQ-033 Frame [5,9,3,9,1] last on 1, thresh=4 -> m_peak=9, m_index=1, m_nhits=3, m_detect=1, m_ovf=0, m_valid one cycle after last.
REQ-034 Single sample 7 with s_last, thresh=8 -> m_peak=7, m_index=0, m_nhits=0, m_detect=0.
REQ-035 1024 samples value=index, no s_last -> m_ovf=1, m_peak=1023, m_index=1023, m_nhits per thresh; next sample starts a fresh frame at index 0.
REQ-036 m_ready held 0 for 5 cycles in REPORT with s_valid=1 -> s_ready=0, outputs stable; accept then s_ready=1 next cycle, no samples lost.
REQ-037 thresh changed 4->100 after first sample of [10,20] -> m_nhits=2 (captured threshold used).
REQ-038 rst pulsed after 3 samples of a frame -> no m_valid; next frame [2,6] reports m_peak=6, m_index=1.
